// File: rtl/posit_pkg.sv
// Shared posit definitions: default geometry, decoded-field record and raw-pattern helpers.
package posit_pkg;

  localparam int POSIT_N     = 8;
  localparam int POSIT_ES    = 3;
  localparam int POSIT_RS    = $clog2(POSIT_N);
  localparam int POSIT_MW    = POSIT_N - POSIT_ES - 2;
  localparam int POSIT_W_MAX = 32;

  // Decoded fields for the default geometry
  typedef struct packed {
    logic                      sign;
    logic signed [POSIT_RS:0]  regime;
    logic [POSIT_ES-1:0]       exponent;
    logic [POSIT_MW-1:0]       mantissa;
    logic                      is_zero;
    logic                      is_nar;
  } posit_fields_t;

  function automatic logic [POSIT_W_MAX-1:0] posit_mask(input int n);
    return (n >= POSIT_W_MAX) ? '1 : ((POSIT_W_MAX'(1) << n) - POSIT_W_MAX'(1));
  endfunction

  // Magnitude of an n-bit two's complement posit, zero-extended to POSIT_W_MAX
  function automatic logic [POSIT_W_MAX-1:0] abs_posit(input logic [POSIT_W_MAX-1:0] x,
                                                       input int n);
    logic [POSIT_W_MAX-1:0] m;
    logic [POSIT_W_MAX-1:0] xm;
    m  = posit_mask(n);
    xm = x & m;
    if (((xm >> (n - 1)) & POSIT_W_MAX'(1)) != '0)
      return (~xm + POSIT_W_MAX'(1)) & m;
    return xm;
  endfunction

  function automatic logic is_nar_pattern(input logic [POSIT_W_MAX-1:0] x, input int n);
    return (x & posit_mask(n)) == (POSIT_W_MAX'(1) << (n - 1));
  endfunction

endpackage

// File: rtl/posit_regime_decode.sv
// Regime decoder: run length of the leading identical bits of the posit body, signed
// regime value, and the body shifted past the regime and its terminator.
module posit_regime_decode #(
  parameter int N  = 8,
  parameter int RS = $clog2(N)
) (
  input  logic [N-2:0] body,
  output logic [RS:0]  regime,
  output logic [N-2:0] rem
);

  logic          lead;
  logic          stop;
  logic [RS:0]   run;
  logic [RS:0]   shamt;

  always_comb begin
    lead  = body[N-2];
    stop  = 1'b0;
    run   = '0;
    for (int i = N - 2; i >= 0; i--) begin
      if (!stop && (body[i] == lead)) run = run + (RS+1)'(1);
      else                            stop = 1'b1;
    end
    // A run of ones encodes k-1, a run of zeros encodes -k
    regime = lead ? (run - (RS+1)'(1)) : ((RS+1)'(0) - run);
    // Skipping the terminator too; a run to the LSB shifts everything out
    shamt  = run + (RS+1)'(1);
    rem    = body << shamt;
  end

endmodule

// File: rtl/posit_extract_pipe.sv
// Two-stage posit field extractor with valid/ready on both sides.
// Define POSIT_EXTRACT_NAR_CNT_EN to add the saturating nar_count output.
module posit_extract_pipe
  import posit_pkg::*;
#(
  parameter  int N  = POSIT_N,
  parameter  int ES = POSIT_ES,
  parameter  int RS = $clog2(N),
  localparam int MW = N - ES - 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          sign,
  output logic [RS:0]   regime,
  output logic [ES-1:0] exponent,
  output logic [MW-1:0] mantissa,
  output logic          is_zero,
  output logic          is_nar
`ifdef POSIT_EXTRACT_NAR_CNT_EN
  ,
  output logic [15:0]   nar_count
`endif
);

  logic advance;

  logic                 vld_p1_q, vld_p1_d;
  logic                 sign_p1_q, sign_p1_d;
  logic [N-2:0]         body_p1_q, body_p1_d;
  logic                 zero_p1_q, zero_p1_d;
  logic                 nar_p1_q, nar_p1_d;

  logic                 vld_p2_q, vld_p2_d;
  logic                 sign_p2_q, sign_p2_d;
  logic signed [RS:0]   regime_p2_q, regime_p2_d;
  logic [ES-1:0]        exp_p2_q, exp_p2_d;
  logic [MW-1:0]        mant_p2_q, mant_p2_d;
  logic                 zero_p2_q, zero_p2_d;
  logic                 nar_p2_q, nar_p2_d;

  logic signed [RS:0]   dec_regime;
  logic [N-2:0]         dec_rem;
  logic [N-1:0]         mant_w;

  always_comb begin
    advance  = out_ready || !vld_p2_q;
    in_ready = advance || !vld_p1_q;
  end

  // ---- stage 1: capture, sign, magnitude, special detection ----
  always_comb begin
    vld_p1_d  = vld_p1_q;
    sign_p1_d = sign_p1_q;
    body_p1_d = body_p1_q;
    zero_p1_d = zero_p1_q;
    nar_p1_d  = nar_p1_q;
    if (in_ready) begin
      vld_p1_d = in_valid;
      if (in_valid) begin
        sign_p1_d = in_data[N-1];
        body_p1_d = (N-1)'(abs_posit(POSIT_W_MAX'(in_data), N));
        zero_p1_d = (in_data == '0);
        nar_p1_d  = is_nar_pattern(POSIT_W_MAX'(in_data), N);
      end
    end
  end

  posit_regime_decode #(.N(N), .RS(RS)) u_regime (
    .body   (body_p1_q),
    .regime (dec_regime),
    .rem    (dec_rem)
  );

  // ---- stage 2: regime, exponent and fraction extraction ----
  always_comb begin
    mant_w      = {1'b1, dec_rem << ES};
    vld_p2_d    = vld_p2_q;
    sign_p2_d   = sign_p2_q;
    regime_p2_d = regime_p2_q;
    exp_p2_d    = exp_p2_q;
    mant_p2_d   = mant_p2_q;
    zero_p2_d   = zero_p2_q;
    nar_p2_d    = nar_p2_q;
    if (advance) begin
      vld_p2_d = vld_p1_q;
      if (vld_p1_q) begin
        zero_p2_d = zero_p1_q;
        nar_p2_d  = nar_p1_q;
        if (zero_p1_q || nar_p1_q) begin
          sign_p2_d   = nar_p1_q;
          regime_p2_d = '0;
          exp_p2_d    = '0;
          mant_p2_d   = '0;
        end else begin
          sign_p2_d   = sign_p1_q;
          regime_p2_d = dec_regime;
          exp_p2_d    = dec_rem[N-2 -: ES];
          mant_p2_d   = MW'(mant_w >> (ES + 2));
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q    <= 1'b0;
      sign_p1_q   <= 1'b0;
      body_p1_q   <= '0;
      zero_p1_q   <= 1'b0;
      nar_p1_q    <= 1'b0;
      vld_p2_q    <= 1'b0;
      sign_p2_q   <= 1'b0;
      regime_p2_q <= '0;
      exp_p2_q    <= '0;
      mant_p2_q   <= '0;
      zero_p2_q   <= 1'b0;
      nar_p2_q    <= 1'b0;
    end else begin
      vld_p1_q    <= vld_p1_d;
      sign_p1_q   <= sign_p1_d;
      body_p1_q   <= body_p1_d;
      zero_p1_q   <= zero_p1_d;
      nar_p1_q    <= nar_p1_d;
      vld_p2_q    <= vld_p2_d;
      sign_p2_q   <= sign_p2_d;
      regime_p2_q <= regime_p2_d;
      exp_p2_q    <= exp_p2_d;
      mant_p2_q   <= mant_p2_d;
      zero_p2_q   <= zero_p2_d;
      nar_p2_q    <= nar_p2_d;
    end
  end

  assign out_valid = vld_p2_q;
  assign sign      = sign_p2_q;
  assign regime    = regime_p2_q;
  assign exponent  = exp_p2_q;
  assign mantissa  = mant_p2_q;
  assign is_zero   = zero_p2_q;
  assign is_nar    = nar_p2_q;

`ifdef POSIT_EXTRACT_NAR_CNT_EN
  logic [15:0] nar_cnt_q, nar_cnt_d;

  always_comb begin
    nar_cnt_d = nar_cnt_q;
    if (vld_p2_q && out_ready && nar_p2_q && (nar_cnt_q != 16'hFFFF))
      nar_cnt_d = nar_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) nar_cnt_q <= '0;
    else        nar_cnt_q <= nar_cnt_d;
  end

  assign nar_count = nar_cnt_q;
`endif

endmodule

// File: tb/tb_posit_extract_pipe.sv
// Bench for posit_extract_pipe: directed spec vectors, back-pressure, random traffic
// against a bit-queue posit decoder, and asynchronous mid-stream reset.
module tb_posit_extract_pipe;
  import posit_pkg::*;

  localparam int N  = POSIT_N;
  localparam int ES = POSIT_ES;
  localparam int RS = POSIT_RS;
  localparam int MW = POSIT_MW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic          sign;
  logic [RS:0]   regime;
  logic [ES-1:0] exponent;
  logic [MW-1:0] mantissa;
  logic          is_zero;
  logic          is_nar;
`ifdef POSIT_EXTRACT_NAR_CNT_EN
  logic [15:0]   nar_count;
`endif

  typedef struct {
    posit_fields_t f;
    int            acc;
  } sb_t;

  sb_t           sb[$];
  int            n_assert = 0;
  int            n_fail   = 0;
  int            cyc      = 0;
  int            delivered = 0;
  bit            have_held = 0;
  posit_fields_t held;
  logic          last_in_ready;

  always #5 clk = ~clk;

  posit_extract_pipe #(.N(N), .ES(ES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sign      (sign),
    .regime    (regime),
    .exponent  (exponent),
    .mantissa  (mantissa),
    .is_zero   (is_zero),
    .is_nar    (is_nar)
`ifdef POSIT_EXTRACT_NAR_CNT_EN
    ,
    .nar_count (nar_count)
`endif
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: read the magnitude as a bit stream and consume fields in order
  function automatic posit_fields_t ref_decode(input logic [N-1:0] p);
    posit_fields_t f;
    bit            q[$];
    bit            lead;
    bit            b;
    int            v;
    int            k;
    f = '0;
    if (p == '0) begin
      f.is_zero = 1'b1;
      return f;
    end
    if (p == N'(1 << (N - 1))) begin
      f.is_nar = 1'b1;
      f.sign   = 1'b1;
      return f;
    end
    f.sign = p[N-1];
    v = p[N-1] ? ((1 << N) - int'(p)) : int'(p);
    for (int i = N - 2; i >= 0; i--) q.push_back(((v >> i) & 1) != 0);
    lead = q[0];
    k = 0;
    while (q.size() > 0 && q[0] == lead) begin
      void'(q.pop_front());
      k++;
    end
    if (q.size() > 0) void'(q.pop_front());
    f.regime = (RS+1)'(lead ? (k - 1) : -k);
    for (int i = 0; i < ES; i++) begin
      b = (q.size() > 0) ? q.pop_front() : 1'b0;
      f.exponent = {f.exponent[ES-2:0], b};
    end
    f.mantissa = MW'(1);
    for (int i = 0; i < MW - 1; i++) begin
      b = (q.size() > 0) ? q.pop_front() : 1'b0;
      f.mantissa = {f.mantissa[MW-2:0], b};
    end
    return f;
  endfunction

  function automatic posit_fields_t observed();
    posit_fields_t o;
    o = {sign, regime, exponent, mantissa, is_zero, is_nar};
    return o;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at the falling edge, check just after, then step to the next falling edge
  task automatic cycle(input logic v, input logic [N-1:0] d, input logic ordy, output logic acc);
    posit_fields_t o;
    sb_t           e;
    logic          exp_ov;
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    #1;
    o = observed();
    last_in_ready = in_ready;
    if (have_held) chk("stall_hold", 64'(o), 64'(held));
    exp_ov = (sb.size() > 0) && ((cyc - sb[0].acc) >= 2);
    chk("out_valid", 64'(out_valid), 64'(exp_ov));
    chk("in_ready", 64'(in_ready), 64'(!(sb.size() >= 2 && !ordy)));
    have_held = out_valid && !out_ready;
    held      = o;
    if (out_valid && out_ready && sb.size() > 0) begin
      e = sb.pop_front();
      chk("fields", 64'(o), 64'(e.f));
      delivered++;
    end
    acc = v && in_ready;
    if (acc) sb.push_back('{ref_decode(d), cyc});
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic directed(input string tag, input logic [N-1:0] d, input posit_fields_t exp);
    logic a;
    cycle(1'b1, d, 1'b1, a);
    chk({tag, "_acc"}, 64'(a), 64'(1));
    cycle(1'b0, '0, 1'b1, a);
    chk({tag, "_valid"}, 64'(out_valid), 64'(1));
    chk({tag, "_fields"}, 64'(observed()), 64'(exp));
  endtask

  initial begin
    logic          a;
    logic [N-1:0]  bb[5];
    logic [N-1:0]  d;
    int            idx;
    int            d0;
    bit            saw_low;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_fields", 64'(observed()), 64'(0));
`ifdef POSIT_EXTRACT_NAR_CNT_EN
    chk("rst_nar_count", 64'(nar_count), 64'(0));
`endif
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'(1));

    // Hand-decoded examples: {sign, regime, exponent, mantissa, is_zero, is_nar}
    directed("ex_r_m1", 8'b0_01_000_01, {1'b0, 4'b1111, 3'b000, 3'b101, 1'b0, 1'b0});
    directed("ex_r_p1", 8'b0_110_011_1, {1'b0, 4'b0001, 3'b011, 3'b110, 1'b0, 1'b0});
    directed("ex_neg",  8'b1_01_000_01, {1'b1, 4'b0000, 3'b111, 3'b111, 1'b0, 1'b0});
    directed("ex_01",   8'h01,          {1'b0, 4'b1010, 3'b000, 3'b100, 1'b0, 1'b0});
    directed("ex_7f",   8'h7F,          {1'b0, 4'b0110, 3'b000, 3'b100, 1'b0, 1'b0});
    directed("ex_zero", 8'h00,          {1'b0, 4'b0000, 3'b000, 3'b000, 1'b1, 1'b0});
    directed("ex_nar",  8'h80,          {1'b1, 4'b0000, 3'b000, 3'b000, 1'b0, 1'b1});
    cycle(1'b0, '0, 1'b1, a);
`ifdef POSIT_EXTRACT_NAR_CNT_EN
    chk("nar_count_1", 64'(nar_count), 64'(1));
`endif
    cycle(1'b0, '0, 1'b1, a);

    // Back-to-back burst with downstream stalled for three cycles
    for (int i = 0; i < 5; i++) bb[i] = N'($urandom);
    idx     = 0;
    saw_low = 0;
    d0      = delivered;
    for (int i = 0; i < 12; i++) begin
      cycle(idx < 4, bb[idx], !(i >= 3 && i <= 5), a);
      if (!last_in_ready) saw_low = 1;
      if (a) idx++;
    end
    chk("bb_in_ready_low", 64'(saw_low), 64'(1));
    chk("bb_accepted", 64'(idx), 64'(4));
    chk("bb_delivered", 64'(delivered - d0), 64'(4));

    // Random traffic with random back-pressure and frequent special values
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0:       d = 8'h00;
        1:       d = 8'h80;
        2:       d = 8'h7F;
        3:       d = 8'h81;
        4:       d = 8'h01;
        default: d = N'($urandom);
      endcase
      cycle($urandom_range(0, 3) != 0, d, $urandom_range(0, 3) != 0, a);
    end
    for (int i = 0; i < 20 && sb.size() > 0; i++) cycle(1'b0, '0, 1'b1, a);
    chk("drain_empty", 64'(sb.size()), 64'(0));

    // Fill both stages with NaR, then reset between clock edges
    cycle(1'b1, 8'h80, 1'b1, a);
    cycle(1'b0, '0, 1'b1, a);
    cycle(1'b0, '0, 1'b1, a);
    cycle(1'b1, 8'h80, 1'b0, a);
    cycle(1'b1, 8'h80, 1'b0, a);
    chk("pre_rst_full", 64'(out_valid), 64'(1));
    #2;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_fields", 64'(observed()), 64'(0));
    chk("mid_rst_in_ready", 64'(in_ready), 64'(1));
`ifdef POSIT_EXTRACT_NAR_CNT_EN
    chk("mid_rst_nar_count", 64'(nar_count), 64'(0));
`endif
    sb.delete();
    have_held = 0;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, '0, 1'b1, a);
    cycle(1'b0, '0, 1'b1, a);
    directed("post_rst", 8'b0_110_011_1, {1'b0, 4'b0001, 3'b011, 3'b110, 1'b0, 1'b0});
    cycle(1'b0, '0, 1'b1, a);
    cycle(1'b0, '0, 1'b1, a);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
